// File: rtl/placar_ctrl.sv
// Score controller: round-robin point-add arbiter, saturating 20-bit score and sequential double-dabble BCD conversion.
// Optional leading-zero blanking of the HEX digits is enabled by defining PLACAR_ZERO_BLANK_EN.
module placar_ctrl #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned PTS_W     = 8,
  parameter int unsigned SCORE_MAX = 999999
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*PTS_W-1:0] pts,
  output logic [N_REQ-1:0]       ack,
  output logic [19:0]            score,
  output logic [23:0]            bcd,
  output logic                   bcd_valid,
  output logic                   busy,
  output logic [5:0]             blank
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned SUM_W = ((PTS_W > 20) ? PTS_W : 20) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [19:0]      score_q, score_d;
  logic [PTR_W-1:0] last_q, last_d;
  logic [43:0]      shreg_q, shreg_d;
  logic [4:0]       iter_q, iter_d;
  logic [23:0]      bcd_q, bcd_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             bval_q, bval_d;

  logic             gnt_vld;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTS_W-1:0] sel_pts;
  logic [SUM_W-1:0] sum;
  logic [19:0]      add_score;

  function automatic logic [23:0] dabble_adj(input logic [23:0] in);
    logic [23:0] out;
    logic [3:0]  nib;
    out = '0;
    for (int unsigned d = 0; d < 6; d++) begin
      nib = in[4*d +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      out[4*d +: 4] = nib;
    end
    return out;
  endfunction

  // Round-robin search starting one past the last granted source.
  always_comb begin
    int unsigned idx;
    gnt_vld = 1'b0;
    gnt_idx = last_q;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(last_q) + k) % N_REQ;
      if (!gnt_vld && req[PTR_W'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    sel_pts   = pts[gnt_idx*PTS_W +: PTS_W];
    sum       = SUM_W'(score_q) + SUM_W'(sel_pts);
    add_score = (sum > SUM_W'(SCORE_MAX)) ? 20'(SCORE_MAX) : sum[19:0];
  end

`ifdef PLACAR_ZERO_BLANK_EN
  logic [5:0] blank_q, blank_d;

  // A digit is dark only if it and every more significant digit are zero.
  function automatic logic [5:0] lz_mask(input logic [23:0] b);
    logic [5:0] m;
    logic       zrun;
    m    = '0;
    zrun = 1'b1;
    for (int unsigned d = 5; d >= 1; d--) begin
      zrun = zrun && (b[4*d +: 4] == 4'd0);
      m[d] = zrun;
    end
    return m;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    last_d  = last_q;
    shreg_d = shreg_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    ack_d   = '0;
    bval_d  = 1'b0;
`ifdef PLACAR_ZERO_BLANK_EN
    blank_d = blank_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (clear) begin
          score_d = '0;
          shreg_d = '0;
          iter_d  = '0;
          state_d = S_CONV;
        end else if (gnt_vld) begin
          score_d = add_score;
          ack_d   = N_REQ'(1) << gnt_idx;
          last_d  = gnt_idx;
          shreg_d = {24'd0, add_score};
          iter_d  = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        shreg_d = {dabble_adj(shreg_q[43:20]), shreg_q[19:0]} << 1;
        iter_d  = iter_q + 5'd1;
        if (iter_q == 5'd19) state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d   = shreg_q[43:20];
        bval_d  = 1'b1;
`ifdef PLACAR_ZERO_BLANK_EN
        blank_d = lz_mask(shreg_q[43:20]);
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      score_q <= '0;
      last_q  <= PTR_W'(N_REQ - 1);
      shreg_q <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
      ack_q   <= '0;
      bval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      last_q  <= last_d;
      shreg_q <= shreg_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      ack_q   <= ack_d;
      bval_q  <= bval_d;
    end
  end

`ifdef PLACAR_ZERO_BLANK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blank_q <= 6'b111110;
    else        blank_q <= blank_d;
  end
  assign blank = blank_q;
`else
  assign blank = 6'b000000;
`endif

  assign ack       = ack_q;
  assign score     = score_q;
  assign bcd       = bcd_q;
  assign bcd_valid = bval_q;
  assign busy      = (state_q != S_IDLE);

endmodule
